// File: rtl/vga_scan_pkg.sv
// Shared VGA scan constants: 640x480@60 timing defaults, widths and the test-bar colour table.
// The bar table is only used when VGA_SCAN_TESTPAT_EN is defined.
package vga_scan_pkg;

  localparam int H_ACTIVE_DEF    = 640;
  localparam int H_FP_DEF        = 16;
  localparam int H_SYNC_DEF      = 96;
  localparam int H_BP_DEF        = 48;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int V_FP_DEF        = 10;
  localparam int V_SYNC_DEF      = 2;
  localparam int V_BP_DEF        = 33;
  localparam int SCALE_SHIFT_DEF = 2;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525

  localparam int COLOR_W  = 12;
  localparam int COORD_W  = 8;
  localparam int CNT_W    = 11;  // covers totals up to 2047
  localparam int NUM_BARS = 8;

  function automatic logic [COLOR_W-1:0] bar_color(input logic [2:0] idx);
    logic [COLOR_W-1:0] c;
    case (idx)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_scan_reader_timing.sv
// vga_timing_gen: pixel-enable divider, h/v scan counters, raw syncs and frame_start pulse.
// Counters advance only on clk edges where the registered pix_en is high.
module vga_timing_gen
  import vga_scan_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pix_en_o,
  output logic [CNT_W-1:0] hcount_o,
  output logic [CNT_W-1:0] vcount_o,
  output logic             active_o,
  output logic             hsync_raw_o,
  output logic             vsync_raw_o,
  output logic             frame_start_o
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic             pix_en_q;
  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             frame_start_q, frame_start_d;
  logic             h_last, v_last;

  assign h_last = (hcount_q == CNT_W'(HT - 1));
  assign v_last = (vcount_q == CNT_W'(VT - 1));

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    if (pix_en_q) begin
      if (h_last) begin
        hcount_d = '0;
        if (v_last) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + CNT_W'(1);
        end
      end else begin
        hcount_d = hcount_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en_q      <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pix_en_q      <= ~pix_en_q;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_en_o      = pix_en_q;
  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;
  assign frame_start_o = frame_start_q;
  assign active_o      = (hcount_q < CNT_W'(H_ACTIVE)) && (vcount_q < CNT_W'(V_ACTIVE));
  assign hsync_raw_o   = !((hcount_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                           (hcount_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
  assign vsync_raw_o   = !((vcount_q >= CNT_W'(V_ACTIVE + V_FP)) &&
                           (vcount_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));

endmodule

// File: rtl/vga_scan_reader.sv
// VGA scan-out of a down-scaled framebuffer: stage 1 issues the read address, stage 2 latches colour.
// Optional colour-bar generator enabled by defining VGA_SCAN_TESTPAT_EN (adds input test_en).
module vga_scan_reader
  import vga_scan_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_FP        = H_FP_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_FP        = V_FP_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter int SCALE_SHIFT = SCALE_SHIFT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  input  logic [COLOR_W-1:0] rd_data,
`ifdef VGA_SCAN_TESTPAT_EN
  input  logic               test_en,
`endif
  output logic [COLOR_W-1:0] vga_rgb,
  output logic               hsync,
  output logic               vsync,
  output logic               vblank,
  output logic               frame_start
);

  logic             pix_en;
  logic [CNT_W-1:0] hcount, vcount;
  logic             active, hsync_raw, vsync_raw;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix_en_o      (pix_en),
    .hcount_o      (hcount),
    .vcount_o      (vcount),
    .active_o      (active),
    .hsync_raw_o   (hsync_raw),
    .vsync_raw_o   (vsync_raw),
    .frame_start_o (frame_start)
  );

  logic [COORD_W-1:0] rd_x_q, rd_x_d, rd_y_q, rd_y_d;
  logic               act1_q, hs1_q, vs1_q, vb1_q;
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               hs2_q, vs2_q, vblank_q;

  assign rd_x_d = active ? COORD_W'(hcount >> SCALE_SHIFT) : '0;
  assign rd_y_d = active ? COORD_W'(vcount >> SCALE_SHIFT) : '0;

`ifdef VGA_SCAN_TESTPAT_EN
  // Bars span the visible framebuffer width evenly, independent of its size.
  localparam int FB_W = H_ACTIVE >> SCALE_SHIFT;
  logic [2:0] bar_idx;
  assign bar_idx = 3'((32'(rd_x_q) * NUM_BARS) / FB_W);
`endif

  always_comb begin
    rgb_d = act1_q ? rd_data : '0;
`ifdef VGA_SCAN_TESTPAT_EN
    if (act1_q && test_en) rgb_d = bar_color(bar_idx);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_x_q   <= '0;
      rd_y_q   <= '0;
      act1_q   <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      vb1_q    <= 1'b0;
      rgb_q    <= '0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      vblank_q <= 1'b0;
    end else if (pix_en) begin
      rd_x_q   <= rd_x_d;
      rd_y_q   <= rd_y_d;
      act1_q   <= active;
      hs1_q    <= hsync_raw;
      vs1_q    <= vsync_raw;
      vb1_q    <= (vcount >= CNT_W'(V_ACTIVE));
      rgb_q    <= rgb_d;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      vblank_q <= vb1_q;
    end
  end

  assign rd_x    = rd_x_q;
  assign rd_y    = rd_y_q;
  assign vga_rgb = rgb_q;
  assign hsync   = hs2_q;
  assign vsync   = vs2_q;
  assign vblank  = vblank_q;

endmodule

// File: tb/tb_vga_scan_reader.sv
// Self-checking bench for vga_scan_reader using reduced timing so whole frames fit in a short run.
// Expected outputs come from a tick-count model of the scan position, not from DUT internals.
module tb_vga_scan_reader;
  import vga_scan_pkg::*;

  localparam int HA = 32, HFP = 4, HSY = 6, HBP = 6;
  localparam int VA = 16, VFP = 2, VSY = 3, VBP = 3;
  localparam int SS = 2;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int TOT = HT * VT;
  localparam int Q_RST = 10 * HT + 20;  // reset lands at hcount=20, vcount=10

  logic               clk, rst_n, test_en;
  logic [COORD_W-1:0] rd_x, rd_y;
  logic [COLOR_W-1:0] rd_data, vga_rgb;
  logic               hsync, vsync, vblank, frame_start;

  logic [COLOR_W-1:0] fb [64][64];

  int checks, errors;
  int clk_n, hs_low, vs_low, fs_ref, fs_cnt;
  bit fs_ref_valid, spot_en;
  logic prev_hs, prev_vs;

  vga_scan_reader #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
    .SCALE_SHIFT (SS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_data     (rd_data),
`ifdef VGA_SCAN_TESTPAT_EN
    .test_en     (test_en),
`endif
    .vga_rgb     (vga_rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .vblank      (vblank),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous framebuffer: data valid one clk after the address changes.
  always @(posedge clk) rd_data <= fb[rd_x[5:0]][rd_y[5:0]];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (clk %0d)", tag, got, exp, clk_n);
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_rgb"},   32'(vga_rgb),     32'h0);
    check_val({tag, "_hsync"}, 32'(hsync),       32'h1);
    check_val({tag, "_vsync"}, 32'(vsync),       32'h1);
    check_val({tag, "_vblank"},32'(vblank),      32'h0);
    check_val({tag, "_fs"},    32'(frame_start), 32'h0);
    check_val({tag, "_rd_x"},  32'(rd_x),        32'h0);
    check_val({tag, "_rd_y"},  32'(rd_y),        32'h0);
  endtask

  task automatic start_run();
    clk_n = 0; hs_low = 0; vs_low = 0;
    prev_hs = 1'b1; prev_vs = 1'b1;
    fs_ref = 0; fs_ref_valid = 1'b1; fs_cnt = 0;
  endtask

  // Pixel ticks happen on every second clk after reset release; after tick k the
  // counters sit at scan position k, stage 1 shows k-1 and the pins show k-2.
  task automatic check_outputs();
    int k, p, h, v;
    logic [COLOR_W-1:0] e_rgb;
    logic [COORD_W-1:0] e_rx, e_ry;
    logic e_hs, e_vs, e_vb, e_fs;
    k = clk_n / 2;
    e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_vb = 1'b0; e_rx = '0; e_ry = '0;
    if (k >= 2) begin
      p = (k - 2) % TOT; h = p % HT; v = p / HT;
      if (h < HA && v < VA) e_rgb = fb[h >> SS][v >> SS];
      e_hs = !(h >= HA + HFP && h < HA + HFP + HSY);
      e_vs = !(v >= VA + VFP && v < VA + VFP + VSY);
      e_vb = (v >= VA);
      if (spot_en && h < HA && v < VA && (h >> SS) == 1 && (v >> SS) == 1)
        check_val("spot_f0a", 32'(vga_rgb), 32'hF0A);
    end
    if (k >= 1) begin
      p = (k - 1) % TOT; h = p % HT; v = p / HT;
      if (h < HA && v < VA) begin
        e_rx = COORD_W'(h >> SS);
        e_ry = COORD_W'(v >> SS);
      end
    end
    e_fs = (clk_n % 2 == 0) && (k > 0) && (k % TOT == 0);
    check_val("rgb",    32'(vga_rgb),     32'(e_rgb));
    check_val("hsync",  32'(hsync),       32'(e_hs));
    check_val("vsync",  32'(vsync),       32'(e_vs));
    check_val("vblank", 32'(vblank),      32'(e_vb));
    check_val("rd_x",   32'(rd_x),        32'(e_rx));
    check_val("rd_y",   32'(rd_y),        32'(e_ry));
    check_val("frame_start", 32'(frame_start), 32'(e_fs));

    if (!hsync) hs_low++;
    else begin
      if (!prev_hs) check_val("hsync_low_clk", 32'(hs_low), 32'(2 * HSY));
      hs_low = 0;
    end
    prev_hs = hsync;
    if (!vsync) vs_low++;
    else begin
      if (!prev_vs) check_val("vsync_low_clk", 32'(vs_low), 32'(2 * VSY * HT));
      vs_low = 0;
    end
    prev_vs = vsync;
    if (frame_start) begin
      if (fs_ref_valid) check_val("frame_period_clk", 32'(clk_n - fs_ref), 32'(2 * TOT));
      fs_ref = clk_n; fs_ref_valid = 1'b1; fs_cnt++;
    end
  endtask

  task automatic run_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      clk_n++;
      @(negedge clk);
      check_outputs();
    end
  endtask

  initial begin
    checks = 0; errors = 0; clk_n = 0;
    rst_n = 1'b0; test_en = 1'b0; spot_en = 1'b1;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        fb[i][j] = COLOR_W'($urandom);
    fb[1][1] = 12'hF0A;

    // Random framebuffer, two full frames from power-on reset.
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    start_run();
    run_check(4 * TOT + 60);
    check_val("frames_seen", 32'(fs_cnt), 32'd2);

    // All-white framebuffer: blanking must still output black and zero addresses.
    rst_n = 1'b0;
    spot_en = 1'b0;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        fb[i][j] = 12'hFFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_run();
    run_check(2 * Q_RST);

    // Asynchronous reset mid-frame, away from any clk edge.
    #2 rst_n = 1'b0;
    #1 check_reset("mid_reset");
    repeat (3) @(negedge clk);
    check_reset("held_reset");
    rst_n = 1'b1;
    start_run();
    run_check(2 * TOT + 20);
    check_val("frames_after_reset", 32'(fs_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
